apb_reg_bank: RTL

//  Parametrised APB4 completer holding NUM_REGS DATA-wide registers, the next generation of our APB sub_ip.

---
 rtl/apb_reg_bank.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/apb_reg_bank.sv
// apb_reg_bank
// APB4 completer holding NUM_REGS registers of DATA bits each. It supports byte
// strobes, a fixed number of PREADY-low wait states in every access phase, and
// PSLVERR on a misaligned, out-of-range or read-only access. A hardware-side
// port can also load any register directly.
//
// Ports:
//   PCLK, PRESETn     clock (rising edge) and synchronous active-low reset
//   PSEL, PENABLE     APB select and access-phase flags
//   PWRITE            1 = write, 0 = read
//   PADDR             byte address; reg i lives at byte offset i*(DATA/8)
//   PWDATA, PSTRB     write data and per-byte write strobes
//   PRDATA            read data, non-zero only while PREADY is high
//   PREADY, PSLVERR   transfer completion and error flag
//   reg_q             all register contents; reg i at [i*DATA +: DATA]
//   reg_wr_pulse      one-cycle pulse per register after a successful APB write
//   hw_we, hw_wdata   per-register hardware load enable and data
module apb_reg_bank #(
   parameter int                     ADDR        = 32,
   parameter int                     DATA        = 32,
   parameter int                     NUM_REGS    = 8,
   parameter int                     WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
   parameter logic [DATA-1:0]        RST_VAL     = '0
) (
   input  logic                     PCLK,
   input  logic                     PRESETn,
   input  logic                     PSEL,
   input  logic                     PENABLE,
   input  logic                     PWRITE,
   input  logic [ADDR-1:0]          PADDR,
   input  logic [DATA-1:0]          PWDATA,
   input  logic [DATA/8-1:0]        PSTRB,
   output logic [DATA-1:0]          PRDATA,
   output logic                     PREADY,
   output logic                     PSLVERR,
   output logic [NUM_REGS*DATA-1:0] reg_q,
   output logic [NUM_REGS-1:0]      reg_wr_pulse,
   input  logic [NUM_REGS-1:0]      hw_we,
   input  logic [NUM_REGS*DATA-1:0] hw_wdata
);

   localparam int STRB = DATA / 8;
   localparam int OFS  = $clog2(STRB);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t              state, state_nxt;
   logic [3:0]          cnt, cnt_nxt;
   logic [DATA-1:0]     regs [NUM_REGS];
   logic [ADDR-1:0]     idx;
   logic [NUM_REGS-1:0] sel;
   logic                misaligned;
   logic                in_range;
   logic                ro_hit;
   logic                err;
   logic                commit;
   logic [DATA-1:0]     rd_mux;

   // The decode covers the full address width. Any upper address bit that is
   // set pushes the index out of range and flags an error instead of aliasing.
   assign idx        = PADDR >> OFS;
   assign misaligned = |(PADDR & ADDR'(STRB - 1));
   assign in_range   = idx < ADDR'(NUM_REGS);
   assign ro_hit     = |(sel & RO_MASK);
   assign err        = misaligned | ~in_range | (PWRITE & ro_hit);

   // One-hot select of the addressed register, used for read mux and commit.
   always_comb begin
      sel    = '0;
      rd_mux = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx == ADDR'(i)) begin
            sel[i] = 1'b1;
            rd_mux = regs[i];
         end
      end
   end

   // The transfer completes when the access phase has used up its wait count.
   assign PREADY  = (state == ACCESS) && (cnt == 4'd0);
   assign PSLVERR = PREADY & err;
   assign PRDATA  = (PREADY & ~err) ? rd_mux : '0;
   assign commit  = PREADY & PSEL & PENABLE & PWRITE & ~err;

   // State and wait-counter register. Reset drops any transfer in flight.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // IDLE waits for a setup phase. ACCESS counts down the wait states and
   // returns to IDLE when the transfer completes or the requester drops PSEL.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               state_nxt = ACCESS;
               cnt_nxt   = 4'(WAIT_STATES);
            end
         end
         ACCESS: begin
            if (!PSEL) begin
               state_nxt = IDLE;
            end else if (cnt != 4'd0) begin
               cnt_nxt = cnt - 4'd1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Register storage. The hardware load is applied first, and the strobed APB
   // bytes are assigned after it. When both hit the same register on the same
   // edge, the strobed bytes come from PWDATA and the rest from hw_wdata.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= RST_VAL;
         end
         reg_wr_pulse <= '0;
      end else begin
         reg_wr_pulse <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (hw_we[i]) begin
               regs[i] <= hw_wdata[i*DATA +: DATA];
            end
            if (commit && sel[i]) begin
               reg_wr_pulse[i] <= 1'b1;
               for (int b = 0; b < STRB; b++) begin
                  if (PSTRB[b]) begin
                     regs[i][b*8 +: 8] <= PWDATA[b*8 +: 8];
                  end
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
      assign reg_q[g*DATA +: DATA] = regs[g];
   end

endmodule
